// File: rtl/uart_byte_rx_pkg.sv
// Shared types and helpers for the 8N1 serial byte receiver.
// Contents: receiver state encoding, data width, counter-width helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Bits needed to count 0..clks-1; never less than one.
    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Signal bundle between the serial pin, the receiver and its consumer.
// slave: receiver view (rx_serial in; data_out/out_valid/frame_err/busy out).
interface uart_byte_rx_if;

    logic       rx_serial;
    logic [7:0] data_out;
    logic       out_valid;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  rx_serial,
        output data_out,
        output out_valid,
        output frame_err,
        output busy
    );

    modport master (
        output rx_serial,
        input  data_out,
        input  out_valid,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/uart_byte_rx_sync_ff.sv
// Multi-stage synchronizer for one asynchronous input; resets to 1 (idle).
// Ports: clk, reset (async high), d_i raw input, q_o synchronized output.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 serial byte receiver with mid-bit sampling and break handling.
// Ports: clk, reset (async high), bus (slave: rx_serial in; data/valid/err/busy out).
module uart_byte_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic           clk,
    input  logic           reset,
    uart_byte_rx_if.slave  bus
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.rx_serial),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        // Still low at mid-bit: a real start bit.
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        // LSB arrives first, so shift in from the top.
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (idx_q == LAST_BIT) begin
                            idx_q   <= '0;
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    // Hold here so a stuck-low line yields one error only.
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
Asynchronous serial byte receiver, 8N1 format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle line high. It sits directly upstream of the even/odd classifier FSM. data_out drives the classifier's data_in[7:0], and out_valid drives its in_valid. The block recovers bytes from a single serial pin using a fixed clocks-per-bit count and mid-bit sampling.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 4; mid-bit point = CLKS_PER_BIT/2 (integer division).
SYNC_STAGES, 2, flip-flop stages in the rx_serial input synchronizer; legal range >= 2.

Ports:
clk        input   1  system clock
reset      input   1  asynchronous, active-high reset
rx_serial  input   1  raw serial line, asynchronous to clk, idles high
data_out   output  8  last correctly framed byte; held until the next good byte
out_valid  output  1  one-cycle pulse: data_out updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
busy       output  1  high whenever state != IDLE

Behaviour:
- Reset values (async, active-high): data_out=8'h00, out_valid=0, frame_err=0, busy=0, state=IDLE, synchronizer flops=1 (line idle), bit counter=0, bit index=0.
- All FSM decisions use the synchronized line rx_s, never raw rx_serial.
- States: IDLE, START, DATA, STOP, BREAK. The state encoding lives in the package.
- IDLE: when rx_s==0, go to START and clear the counter.
- START: count to CLKS_PER_BIT/2-1, then sample rx_s.
  - rx_s==0: go to DATA; counter=0, bit_idx=0.
  - rx_s==1: glitch / false start; return to IDLE with no output pulse.
- DATA: at counter==CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (LSB-first reception) and clear the counter.
  - After the 8th sample (bit_idx==7), go to STOP. Otherwise increment bit_idx.
- STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: next clock edge loads data_out from the shift register, out_valid=1 for exactly one cycle, state goes to IDLE.
  - rx_s==0: frame_err=1 for one cycle, data_out unchanged, no out_valid, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A line held low does not generate repeated frames or errors.
- Latency: stop-bit sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the IDLE cycle that first sees rx_s==0. out_valid rises on the following edge. Add SYNC_STAGES cycles when measuring from the pin.
- out_valid and frame_err are registered and never high together.
- Back-to-back frames: a start bit immediately after the stop bit is detected. IDLE is re-entered in the cycle after the stop sample, which leaves ~CLKS_PER_BIT/2 margin.
- Reset mid-frame: immediate return to IDLE, the partial byte is discarded, and no pulse is produced after reset deasserts.
- No backpressure: the downstream stage must accept every out_valid pulse.

Decomposition:
- Package uart_rx_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}, 3-bit.
  - DATA_BITS=8.
  - Counter-width function $clog2(CLKS_PER_BIT).
- Sub-module sync_ff: SYNC_STAGES-deep synchronizer with reset value 1, instantiated once for rx_serial.

Test Plan:
- Send 8'hA5 with CLKS_PER_BIT=16 -> one out_valid pulse, data_out=8'hA5, frame_err never asserted, busy high for the whole frame.
- Send 8'h00 then 8'hFF back-to-back, zero idle gap -> two out_valid pulses 160 cycles apart, data_out=8'h00 then 8'hFF.
- 3-cycle low glitch on idle line -> START aborts, busy returns low within 10 cycles, no out_valid or frame_err.
- Frame 8'h3C with stop bit forced 0 and line held low 50 bit-times -> exactly one frame_err pulse, data_out keeps its previous value, busy stays high until the line returns high.
- Assert reset for 2 cycles after 4 data bits of 8'h5A, then send 8'h81 -> no pulse from the aborted frame, out_valid with data_out=8'h81.
- Feed 8'h07 then 8'h10 into the downstream classifier -> classifier reports odd after the first byte and even after the second.
